branch_predictor_gshare: RTL and testbench

//  Parametrised dynamic branch predictor for the 5-stage pipeline; replaces the fixed predictor.

---
 rtl/bp_pkg.sv | 35 +++
 rtl/bp_btb.sv | 73 +++++++
 rtl/branch_predictor_gshare.sv | 169 ++++++++++++++++
 tb/tb_branch_predictor_gshare.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bp_pkg
// Description : Shared constants and width helpers for the gshare/bimodal
//               branch predictor and its target buffer.
//               - BP_BIMODAL / BP_GSHARE : MODE encodings
//               - ctr_init / ctr_max     : saturating-counter reset / ceiling
//               - idx_width / tag_width  : table index and BTB tag widths
// Revision    : 1.0 - initial release
// ============================================================================
package bp_pkg;

    localparam int BP_BIMODAL = 0;
    localparam int BP_GSHARE  = 1;

    // Weakly not-taken: the value just below the taken threshold.
    function automatic int ctr_init(input int ctr_bits);
        return (1 << (ctr_bits - 1)) - 1;
    endfunction

    function automatic int ctr_max(input int ctr_bits);
        return (1 << ctr_bits) - 1;
    endfunction

    function automatic int idx_width(input int entries);
        return $clog2(entries);
    endfunction

    // Word-aligned PCs: bits [1:0] are never part of index or tag.
    function automatic int tag_width(input int xlen, input int entries);
        return xlen - $clog2(entries) - 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bp_btb.sv
`default_nettype none
// ============================================================================
// Module      : bp_btb
// Description : Direct-mapped branch target buffer. Combinational read,
//               synchronous write, asynchronous clear of the valid bits.
// Ports       : clk, rst (async, active-low)
//               rd_pc_i      lookup PC
//               rd_hit_o     valid entry with matching tag
//               rd_target_o  stored target when hit, else 0
//               wr_en_i      install/overwrite entry for wr_pc_i
//               wr_pc_i      PC owning the entry
//               wr_target_i  target to store
// Revision    : 1.0 - initial release
// ============================================================================
module bp_btb
    import bp_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] rd_pc_i,
    output logic            rd_hit_o,
    output logic [XLEN-1:0] rd_target_o,
    input  logic            wr_en_i,
    input  logic [XLEN-1:0] wr_pc_i,
    input  logic [XLEN-1:0] wr_target_i
);

    localparam int BIDX_W = idx_width(ENTRIES);
    localparam int TAG_W  = tag_width(XLEN, ENTRIES);

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [XLEN-1:0]    target_q [ENTRIES];

    logic [BIDX_W-1:0]  w_rd_idx;
    logic [BIDX_W-1:0]  w_wr_idx;
    logic [TAG_W-1:0]   w_rd_tag;
    logic [TAG_W-1:0]   w_wr_tag;
    logic               w_unused;

    assign w_rd_idx = rd_pc_i[BIDX_W+1:2];
    assign w_rd_tag = rd_pc_i[XLEN-1:BIDX_W+2];
    assign w_wr_idx = wr_pc_i[BIDX_W+1:2];
    assign w_wr_tag = wr_pc_i[XLEN-1:BIDX_W+2];
    assign w_unused = ^{rd_pc_i[1:0], wr_pc_i[1:0]};

    assign rd_hit_o    = valid_q[w_rd_idx] && (tag_q[w_rd_idx] == w_rd_tag);
    // Gating the target keeps the output at zero while nothing is installed.
    assign rd_target_o = rd_hit_o ? target_q[w_rd_idx] : '0;

    // Only the valid bits are cleared; a cleared entry hides its tag/target.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[w_wr_idx] <= 1'b1;
        end
    end

    // A write coinciding with reset lands here but stays invisible because
    // the matching valid bit is held clear.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_q[w_wr_idx]    <= w_wr_tag;
            target_q[w_wr_idx] <= wr_target_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/branch_predictor_gshare.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor_gshare
// Description : Dynamic branch predictor: saturating-counter PHT indexed by
//               PC (bimodal) or PC XOR global history (gshare), plus a
//               direct-mapped BTB. Zero-latency fetch lookup, one training
//               update per cycle from execute, saturating statistics.
// Ports       : clk, rst (async, active-low)
//               pc_f, predict_f, target_f, btb_hit_f, ghr_f  - fetch lookup
//               upd_en, upd_pc, upd_ghr, upd_taken, upd_target,
//               upd_cond, upd_mispredict                     - training
//               stat_branches, stat_mispred                  - statistics
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor_gshare
    import bp_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int PHT_ENTRIES = 64,
    parameter int CTR_BITS    = 2,
    parameter int GHR_BITS    = 6,
    parameter int BTB_ENTRIES = 16,
    parameter int MODE        = BP_GSHARE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [XLEN-1:0]     pc_f,
    output logic                predict_f,
    output logic [XLEN-1:0]     target_f,
    output logic                btb_hit_f,
    output logic [GHR_BITS-1:0] ghr_f,
    input  logic                upd_en,
    input  logic [XLEN-1:0]     upd_pc,
    input  logic [GHR_BITS-1:0] upd_ghr,
    input  logic                upd_taken,
    input  logic [XLEN-1:0]     upd_target,
    input  logic                upd_cond,
    input  logic                upd_mispredict,
    output logic [31:0]         stat_branches,
    output logic [31:0]         stat_mispred
);

    localparam int                  IDX_W    = idx_width(PHT_ENTRIES);
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(ctr_init(CTR_BITS));
    localparam logic [CTR_BITS-1:0] CTR_MAX  = CTR_BITS'(ctr_max(CTR_BITS));

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CTR_BITS-1:0] pht_q [PHT_ENTRIES];
    logic [GHR_BITS-1:0] ghr_q;
    logic [GHR_BITS-1:0] ghr_d;
    logic [31:0]         stat_branches_q;
    logic [31:0]         stat_branches_d;
    logic [31:0]         stat_mispred_q;
    logic [31:0]         stat_mispred_d;

    logic [IDX_W-1:0]    w_fidx;
    logic [IDX_W-1:0]    w_uidx;
    logic [CTR_BITS-1:0] w_fctr;
    logic [CTR_BITS-1:0] w_uctr;
    logic [CTR_BITS-1:0] w_uctr_next;
    logic [GHR_BITS-1:0] w_ghr_shift;
    logic                w_train;

    // History is zero-extended into the index; bimodal ignores it.
    function automatic logic [IDX_W-1:0] pht_index(
        input logic [XLEN-1:0]     pc,
        input logic [GHR_BITS-1:0] hist
    );
        logic [IDX_W-1:0] h;
        h = '0;
        if (MODE == BP_GSHARE) begin
            h[GHR_BITS-1:0] = hist;
        end
        return pc[IDX_W+1:2] ^ h;
    endfunction

    // ------------------------------------------------------------------
    // Fetch-side lookup (no bypass from a same-cycle update)
    // ------------------------------------------------------------------
    assign w_fidx    = pht_index(pc_f, ghr_q);
    assign w_fctr    = pht_q[w_fidx];
    assign predict_f = w_fctr[CTR_BITS-1] & btb_hit_f;
    assign ghr_f     = ghr_q;

    bp_btb #(
        .XLEN    (XLEN),
        .ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk         (clk),
        .rst         (rst),
        .rd_pc_i     (pc_f),
        .rd_hit_o    (btb_hit_f),
        .rd_target_o (target_f),
        .wr_en_i     (upd_en & upd_taken),
        .wr_pc_i     (upd_pc),
        .wr_target_i (upd_target)
    );

    // ------------------------------------------------------------------
    // Execute-side training. The index uses the history captured at fetch,
    // so training lands on the entry that produced the prediction.
    // ------------------------------------------------------------------
    assign w_train = upd_en & upd_cond;
    assign w_uidx  = pht_index(upd_pc, upd_ghr);
    assign w_uctr  = pht_q[w_uidx];

    always_comb begin
        w_uctr_next = w_uctr;
        if (upd_taken) begin
            if (w_uctr != CTR_MAX) begin
                w_uctr_next = w_uctr + 1'b1;
            end
        end else begin
            if (w_uctr != '0) begin
                w_uctr_next = w_uctr - 1'b1;
            end
        end
    end

    if (GHR_BITS == 1) begin : g_ghr_single
        assign w_ghr_shift = upd_taken;
    end else begin : g_ghr_multi
        assign w_ghr_shift = {ghr_q[GHR_BITS-2:0], upd_taken};
    end

    always_comb begin
        ghr_d           = ghr_q;
        stat_branches_d = stat_branches_q;
        stat_mispred_d  = stat_mispred_q;
        if (w_train) begin
            ghr_d = w_ghr_shift;
            if (stat_branches_q != '1) begin
                stat_branches_d = stat_branches_q + 32'd1;
            end
        end
        if (upd_en && upd_mispredict && (stat_mispred_q != '1)) begin
            stat_mispred_d = stat_mispred_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < PHT_ENTRIES; i++) begin
                pht_q[i] <= CTR_INIT;
            end
        end else if (w_train) begin
            pht_q[w_uidx] <= w_uctr_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ghr_q           <= '0;
            stat_branches_q <= '0;
            stat_mispred_q  <= '0;
        end else begin
            ghr_q           <= ghr_d;
            stat_branches_q <= stat_branches_d;
            stat_mispred_q  <= stat_mispred_d;
        end
    end

    assign stat_branches = stat_branches_q;
    assign stat_mispred  = stat_mispred_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor_gshare.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_predictor_gshare
// Description : Scoreboard bench for branch_predictor_gshare. One gshare and
//               one bimodal instance share stimulus; a reference model of
//               tables and counters predicts every fetch-side output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predictor_gshare;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc_f = '0;
    logic        upd_en = 1'b0;
    logic [31:0] upd_pc = '0;
    logic [5:0]  upd_ghr = '0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = '0;
    logic        upd_cond = 1'b0;
    logic        upd_mispredict = 1'b0;

    logic        pred_g, hit_g, pred_b, hit_b;
    logic [31:0] tgt_g, tgt_b, sb_g, sm_g, sb_b, sm_b;
    logic [5:0]  ghr_g, ghr_b;

    always #5 clk = ~clk;

    branch_predictor_gshare #(.MODE(1)) dut_g (
        .clk(clk), .rst(rst), .pc_f(pc_f), .predict_f(pred_g), .target_f(tgt_g),
        .btb_hit_f(hit_g), .ghr_f(ghr_g), .upd_en(upd_en), .upd_pc(upd_pc),
        .upd_ghr(upd_ghr), .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_cond(upd_cond), .upd_mispredict(upd_mispredict),
        .stat_branches(sb_g), .stat_mispred(sm_g)
    );

    branch_predictor_gshare #(.MODE(0)) dut_b (
        .clk(clk), .rst(rst), .pc_f(pc_f), .predict_f(pred_b), .target_f(tgt_b),
        .btb_hit_f(hit_b), .ghr_f(ghr_b), .upd_en(upd_en), .upd_pc(upd_pc),
        .upd_ghr(upd_ghr), .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_cond(upd_cond), .upd_mispredict(upd_mispredict),
        .stat_branches(sb_b), .stat_mispred(sm_b)
    );

    // ---------------- reference model ----------------
    int unsigned m_ctr [2][64];   // [mode][index]
    int unsigned m_ghr;
    bit          m_valid [16];
    int unsigned m_bpc   [16];
    int unsigned m_btgt  [16];
    longint      m_sb, m_sm;

    typedef struct {
        bit          pg;
        bit          pb;
        bit          hit;
        int unsigned tgt;
        int unsigned ghr;
        longint      sb;
        longint      sm;
    } exp_t;

    exp_t exp_q[$];

    int n_total  = 0;
    int n_passed = 0;

    task automatic chk(input string name, input longint act, input longint req);
        n_total++;
        if (act == req) n_passed++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    endtask

    function automatic int unsigned m_pidx(input int mode, input int unsigned pc,
                                           input int unsigned hist);
        return ((pc / 4) % 64) ^ (mode == 1 ? (hist % 64) : 0);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 64; i++) begin
            m_ctr[0][i] = 1;
            m_ctr[1][i] = 1;
        end
        for (int i = 0; i < 16; i++) m_valid[i] = 0;
        m_ghr = 0;
        m_sb  = 0;
        m_sm  = 0;
    endfunction

    function automatic exp_t model_lookup(input int unsigned pc);
        exp_t        e;
        int unsigned b;
        b     = (pc / 4) % 16;
        e.hit = m_valid[b] && ((m_bpc[b] / 64) == (pc / 64));
        e.tgt = e.hit ? m_btgt[b] : 0;
        e.pg  = e.hit && (m_ctr[1][m_pidx(1, pc, m_ghr)] >= 2);
        e.pb  = e.hit && (m_ctr[0][m_pidx(0, pc, m_ghr)] >= 2);
        e.ghr = m_ghr;
        e.sb  = m_sb;
        e.sm  = m_sm;
        return e;
    endfunction

    function automatic void model_update(input int unsigned pc, input int unsigned hist,
                                         input bit tk, input int unsigned tgt,
                                         input bit cnd, input bit mp);
        int unsigned i;
        if (cnd) begin
            for (int m = 0; m < 2; m++) begin
                i = m_pidx(m, pc, hist);
                if (tk && m_ctr[m][i] < 3) m_ctr[m][i]++;
                if (!tk && m_ctr[m][i] > 0) m_ctr[m][i]--;
            end
            m_ghr = ((m_ghr * 2) + (tk ? 1 : 0)) % 64;
            if (m_sb < 64'hFFFF_FFFF) m_sb++;
        end
        if (tk) begin
            m_valid[(pc / 4) % 16] = 1;
            m_bpc[(pc / 4) % 16]   = pc;
            m_btgt[(pc / 4) % 16]  = tgt;
        end
        if (mp && m_sm < 64'hFFFF_FFFF) m_sm++;
    endfunction

    // ---------------- stimulus ----------------
    task automatic cycle(input bit rv, input logic [31:0] pc, input bit en,
                         input logic [31:0] upc, input logic [5:0] hist, input bit tk,
                         input logic [31:0] tgt, input bit cnd, input bit mp);
        @(negedge clk);
        rst = rv; pc_f = pc; upd_en = en; upd_pc = upc; upd_ghr = hist;
        upd_taken = tk; upd_target = tgt; upd_cond = cnd; upd_mispredict = mp;
        if (!rv) model_reset();
        exp_q.push_back(model_lookup(pc));
        if (rv && en) model_update(upc, hist, tk, tgt, cnd, mp);
    endtask

    task automatic idle(input logic [31:0] pc);
        cycle(1'b1, pc, 1'b0, 32'h0, 6'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_pred_g", pred_g, e.pg);
                chk("sb_pred_b", pred_b, e.pb);
                chk("sb_hit_g", hit_g, e.hit);
                chk("sb_hit_b", hit_b, e.hit);
                chk("sb_tgt_g", tgt_g, e.tgt);
                chk("sb_tgt_b", tgt_b, e.tgt);
                chk("sb_ghr_g", ghr_g, e.ghr);
                chk("sb_ghr_b", ghr_b, e.ghr);
                chk("sb_stat_br", sb_g, e.sb);
                chk("sb_stat_mp", sm_g, e.sm);
                chk("sb_stat_br_b", sb_b, e.sb);
                chk("sb_stat_mp_b", sm_b, e.sm);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- test sequence ----------------
    initial begin
        int          mg, mb;
        bit          tk;
        logic [31:0] pool [12];
        logic [31:0] a, b;

        model_reset();
        repeat (3) cycle(1'b0, 32'h100, 1'b0, 32'h0, 6'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        idle(32'h100);

        // Saturation on the bimodal instance
        repeat (3) cycle(1'b1, 32'h100, 1'b1, 32'h100, 6'(m_ghr), 1'b1, 32'h40, 1'b1, 1'b0);
        idle(32'h100);
        #1;
        chk("sat_pred_after3", pred_b, 1);
        chk("sat_tgt_after3", tgt_b, 32'h40);
        repeat (5) cycle(1'b1, 32'h100, 1'b1, 32'h100, 6'(m_ghr), 1'b1, 32'h40, 1'b1, 1'b0);
        cycle(1'b1, 32'h100, 1'b1, 32'h100, 6'(m_ghr), 1'b0, 32'h0, 1'b1, 1'b0);
        idle(32'h100);
        #1;
        chk("sat_pred_after_1nt", pred_b, 1);
        cycle(1'b1, 32'h100, 1'b1, 32'h100, 6'(m_ghr), 1'b0, 32'h0, 1'b1, 1'b0);
        idle(32'h100);
        #1;
        chk("sat_pred_after_2nt", pred_b, 0);
        chk("sat_btb_kept_on_nt", hit_b, 1);

        // Same-cycle lookup and update of one entry
        cycle(1'b1, 32'h100, 1'b1, 32'h100, 6'(m_ghr), 1'b1, 32'h44, 1'b1, 1'b0);
        #1;
        chk("hazard_old_pred", pred_b, 0);
        chk("hazard_old_tgt", tgt_b, 32'h40);
        idle(32'h100);
        #1;
        chk("hazard_new_pred", pred_b, 1);
        chk("hazard_new_tgt", tgt_b, 32'h44);

        // Alternating branch: history separates the two outcomes
        mg = 0;
        mb = 0;
        for (int k = 0; k < 40; k++) begin
            tk = (k % 2) == 0;
            cycle(1'b1, 32'h200, 1'b1, 32'h200, 6'(m_ghr), tk, 32'h280, 1'b1, 1'b0);
            #1;
            if (k >= 20) begin
                if (pred_g != tk) mg++;
                if (pred_b != tk) mb++;
            end
        end
        chk("gshare_alt_mispredicts", mg, 0);
        chk("bimodal_alt_mispredict_ge_half", (mb >= 10) ? 1 : 0, 1);

        // BTB conflict: same index, different tag
        cycle(1'b1, 32'h0, 1'b1, 32'h010, 6'(m_ghr), 1'b1, 32'hA0, 1'b0, 1'b0);
        cycle(1'b1, 32'h0, 1'b1, 32'h050, 6'(m_ghr), 1'b1, 32'hB0, 1'b0, 1'b0);
        idle(32'h010);
        #1;
        chk("btb_conflict_evicted", hit_g, 0);
        idle(32'h050);
        #1;
        chk("btb_conflict_hit", hit_g, 1);
        chk("btb_conflict_tgt", tgt_g, 32'hB0);

        // Randomised traffic
        for (int i = 0; i < 12; i++) pool[i] = $urandom & 32'hC000_00FC;
        for (int i = 0; i < 300; i++) begin
            a = pool[$urandom_range(0, 11)];
            b = pool[$urandom_range(0, 11)];
            cycle(1'b1, a, 1'($urandom), b,
                  ($urandom_range(0, 1) != 0) ? 6'(m_ghr) : 6'($urandom_range(0, 63)),
                  1'($urandom), $urandom & 32'hFFFF_FFFC, 1'($urandom), 1'($urandom));
        end

        // Reset asserted while an update is presented
        cycle(1'b0, 32'h050, 1'b1, 32'h050, 6'(m_ghr), 1'b1, 32'hC0, 1'b1, 1'b1);
        #1;
        chk("rst_pred", pred_g, 0);
        chk("rst_hit", hit_g, 0);
        chk("rst_ghr", ghr_g, 0);
        chk("rst_stat_br", sb_g, 0);
        chk("rst_stat_mp", sm_g, 0);
        cycle(1'b0, 32'h050, 1'b1, 32'h050, 6'(m_ghr), 1'b1, 32'hC0, 1'b1, 1'b1);
        idle(32'h050);
        #1;
        chk("rst_update_discarded", hit_g, 0);

        // Statistics
        for (int k = 0; k < 10; k++)
            cycle(1'b1, 32'h300, 1'b1, 32'h300 + 32'(4 * k), 6'(m_ghr),
                  (k % 2) == 0, 32'h400, 1'b1, k < 3);
        cycle(1'b1, 32'h300, 1'b1, 32'h340, 6'(m_ghr), 1'b1, 32'h500, 1'b0, 1'b0);
        cycle(1'b1, 32'h300, 1'b1, 32'h344, 6'(m_ghr), 1'b1, 32'h504, 1'b0, 1'b0);
        idle(32'h300);
        #1;
        chk("stat_branches_10", sb_g, 10);
        chk("stat_mispred_3", sm_g, 3);
        #1;
        force dut_g.stat_branches_q = 32'hFFFF_FFFE;
        force dut_g.stat_mispred_q  = 32'hFFFF_FFFE;
        force dut_b.stat_branches_q = 32'hFFFF_FFFE;
        force dut_b.stat_mispred_q  = 32'hFFFF_FFFE;
        m_sb = 64'hFFFF_FFFE;
        m_sm = 64'hFFFF_FFFE;
        #1;
        release dut_g.stat_branches_q;
        release dut_g.stat_mispred_q;
        release dut_b.stat_branches_q;
        release dut_b.stat_mispred_q;
        repeat (3) cycle(1'b1, 32'h300, 1'b1, 32'h300, 6'(m_ghr), 1'b1, 32'h400, 1'b1, 1'b1);
        idle(32'h300);
        #1;
        chk("stat_branches_saturated", sb_g, 64'hFFFF_FFFF);
        chk("stat_mispred_saturated", sm_g, 64'hFFFF_FFFF);

        repeat (3) @(negedge clk);
        #2;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule
`default_nettype wire
